// File: rtl/sipo_deframer_if.sv
// sipo_deframer_if: serial receive side plus parallel valid/ready output of
// the SIPO deframer, bundled as one interface.
//   master : stream source / word consumer (drives serial_*, clear, out_ready)
//   slave  : the deframer (drives data_out, out_valid, bit_count, overflow,
//            parity_err)
// WIDTH must match the deframer instance it connects to.
interface sipo_deframer_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             serial_in;
  logic             serial_valid;
  logic             clear;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    bit_count;
  logic             overflow;
  logic             parity_err;

  modport master (
    output serial_in, serial_valid, clear, out_ready,
    input  data_out, out_valid, bit_count, overflow, parity_err
  );

  modport slave (
    input  serial_in, serial_valid, clear, out_ready,
    output data_out, out_valid, bit_count, overflow, parity_err
  );
endinterface

// File: rtl/sipo_deframer.sv
// sipo_deframer: serial-in parallel-out receive register. Collects one frame
// of serial bits, then holds the assembled word on a valid/ready output.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       sipo_deframer_if.slave: serial_in, serial_valid, clear (inputs),
//             data_out, out_valid, out_ready (handshake), bit_count,
//             overflow (sticky dropped word), parity_err (sticky)
// Parameters: WIDTH (2..32) data bits, MSB_FIRST (1: first bit -> MSB).
// Optional macro SIPO_PARITY_CHECK_EN: frame carries a trailing even-parity
// bit (FRAME = WIDTH+1); otherwise parity_err is tied to 0.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  sipo_deframer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next, w_word, r_data;
  logic [CW-1:0]    r_bit_count;
  logic             r_overflow;
  logic             w_sample, w_complete, w_load, w_drop;

  // clear discards the bit offered on the same edge
  assign w_sample   = bus.serial_valid && !bus.clear;
  assign w_complete = w_sample && (r_bit_count == CW'(FRAME - 1));

  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST) w_shift_next = {r_shift[WIDTH-2:0], bus.serial_in};
    else           w_shift_next = {bus.serial_in, r_shift[WIDTH-1:1]};
  end

`ifdef SIPO_PARITY_CHECK_EN
  // Last frame bit is parity: data is already complete in r_shift.
  logic r_parity_err;
  logic w_parity_bad;
  assign w_word       = r_shift;
  assign w_parity_bad = ^{r_shift, bus.serial_in};

  always_ff @(posedge clk) begin
    if (rst || bus.clear)               r_parity_err <= 1'b0;
    else if (w_complete && w_parity_bad) r_parity_err <= 1'b1;
  end
  assign bus.parity_err = r_parity_err;
`else
  assign w_word         = w_shift_next;
  assign bus.parity_err = 1'b0;
`endif

  // Output holding register FSM
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      EMPTY: if (w_complete) w_state_next = FULL;
      FULL:  if (!w_complete && bus.out_ready) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  // A completed word is accepted unless the pending one is not being consumed
  assign w_load = w_complete && ((r_state == EMPTY) || bus.out_ready);
  assign w_drop = w_complete && (r_state == FULL) && !bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_shift     <= '0;
      r_bit_count <= '0;
      r_data      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (bus.clear) begin
        r_shift     <= '0;
        r_bit_count <= '0;
        r_overflow  <= 1'b0;
      end else if (bus.serial_valid) begin
        if (w_complete) begin
          r_shift     <= '0;
          r_bit_count <= '0;
        end else begin
          r_shift     <= w_shift_next;
          r_bit_count <= r_bit_count + 1'b1;
        end
      end
      if (w_load) r_data     <= w_word;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.data_out  = r_data;
  assign bus.out_valid = (r_state == FULL);
  assign bus.bit_count = r_bit_count;
  assign bus.overflow  = r_overflow;
endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-in, parallel-out receive register with a bit counter and an output holding register using a valid/ready handshake.
- Collects WIDTH serial bits into one word, then presents the word on a valid/ready interface.
- Receive-side counterpart of the team's parallel-load shift register: one serial stream in, one parallel word out to the downstream consumer.

Parameters:
- WIDTH, 4, data bits per word (2..32).
- MSB_FIRST, 1, 1: the first serial bit received lands in data_out[WIDTH-1]; 0: the first bit lands in data_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is sampled at this edge when high.
- clear  input  1  synchronous realign: drops the partial word, clears overflow and parity_err; does not touch the holding register.
- data_out  output  WIDTH  assembled word (holding register).
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- bit_count  output  clog2(WIDTH+1)  bits collected in the current frame.
- overflow  output  1  sticky: a completed word was dropped.
- parity_err  output  1  sticky parity error; constant 0 when the optional feature is off.

Behaviour:
- Reset (rst=1 at an edge):
  - data_out=0, out_valid=0, bit_count=0, overflow=0, parity_err=0, shift register=0.
  - rst overrides all other inputs, including mid-frame; the partial word is discarded.
- Shift:
  - On each edge with serial_valid=1, serial_in enters the shift register and bit_count increments.
  - Edges with serial_valid=0 hold all state.
- Frame complete: the edge where the last frame bit is sampled (bit_count==FRAME-1 && serial_valid).
  - Frame state machine has two states: COLLECT (bit_count < FRAME) and complete, which is a single-edge event. It returns to bit_count=0 on the same edge.
  - FRAME = WIDTH, or WIDTH+1 with the parity option.
  - The completed word, including the bit sampled on that edge, is written to data_out, and out_valid=1 from the next cycle.
  - Latency is one edge from the last serial bit to out_valid.
- Output state machine:
  - EMPTY (out_valid=0) goes to FULL on frame complete.
  - FULL goes to EMPTY on out_valid && out_ready with no frame complete on the same edge.
- Simultaneous events:
  - FULL with out_ready=1 and frame complete on the same edge: the old word is consumed and the new word is loaded. out_valid stays 1, overflow unchanged.
  - FULL with out_ready=0 and frame complete: the new word is dropped, data_out is unchanged, overflow is set to 1 (sticky).
  - clear together with serial_valid: clear wins. bit_count=0 and the bit is discarded. out_valid and data_out are unchanged; a handshake on the same edge still completes.
  - clear and rst together: rst wins.
- Wrap-around: bit_count never exceeds FRAME-1 between edges. The next serial bit after a completion starts a new frame.
- data_out is stable while out_valid=1 and no handshake occurs.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Each frame carries one even-parity bit after the WIDTH data bits; FRAME=WIDTH+1.
  - The parity bit is not stored in data_out.
  - On frame complete, if the XOR of the data bits and the parity bit is 1, parity_err is set (sticky). The word is still delivered.
  - parity_err is cleared only by rst or clear.
- Undefined: FRAME=WIDTH, and parity_err is tied to 0.

Test Plan:
- Reset, then with WIDTH=4 and MSB_FIRST=1 shift 1,0,1,0 on consecutive edges -> data_out=4'b1010 and out_valid=1 one cycle after the 4th bit; bit_count returns to 0.
- Same bits with MSB_FIRST=0 -> data_out=4'b0101.
- Hold out_ready=0 and send 1010 then 1111 -> data_out stays 1010 and overflow=1. Assert out_ready -> out_valid=0. Pulse clear -> overflow=0.
- out_ready=1 on the same edge the next frame (0011) completes while 1010 is pending -> 1010 is consumed, data_out=0011, out_valid stays 1, overflow=0.
- Send two bits, gap serial_valid low for 3 cycles, assert rst mid-frame, then send 1100 -> bit_count=0 after rst and data_out=1100. With clear instead of rst, the same result.
- SIPO_PARITY_CHECK_EN defined: send 1010 with parity 0 -> parity_err=0. Send 1000 with parity 0 -> data_out=1000, parity_err=1.
